// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong sequencer and the start button, ball/paddle
// controllers and score display; the sequencer connects through the slave modport.
interface pong_game_ctrl_if;
   logic       i_start;
   logic [5:0] i_ball_x;
   logic [5:0] i_ball_y;
   logic [5:0] i_paddle1_y;
   logic [5:0] i_paddle2_y;
   logic       o_game_active;
   logic [3:0] o_p1_score;
   logic [3:0] o_p2_score;
   logic       o_point_pulse;
   logic [1:0] o_winner;
   logic [1:0] o_state;

   modport master (
      output i_start, i_ball_x, i_ball_y, i_paddle1_y, i_paddle2_y,
      input  o_game_active, o_p1_score, o_p2_score, o_point_pulse, o_winner, o_state
   );

   modport slave (
      input  i_start, i_ball_x, i_ball_y, i_paddle1_y, i_paddle2_y,
      output o_game_active, o_p1_score, o_p2_score, o_point_pulse, o_winner, o_state
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serves on the start edge, awards points on wall misses,
// pauses between points and declares a winner at the score limit.
module pong_game_ctrl #(
   parameter int c_game_width    = 40,
   parameter int c_game_height   = 30,
   parameter int c_paddle_height = 6,
   parameter int c_score_limit   = 9,
   parameter int c_serve_delay   = 25000000
) (
   input logic        i_clk,
   input logic        i_rst_n,
   pong_game_ctrl_if.slave game
);

   localparam int                 c_cnt_w       = (c_serve_delay > 1) ? $clog2(c_serve_delay) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last    = c_cnt_w'(c_serve_delay - 1);
   localparam logic [5:0]         c_right_col   = 6'(c_game_width - 1);
   localparam logic [6:0]         c_paddle_span = 7'(c_paddle_height - 1);
   localparam logic [3:0]         c_limit       = 4'(c_score_limit);

   if (c_score_limit < 1 || c_score_limit > 15) begin : g_bad_limit
      $error("pong_game_ctrl: c_score_limit must be 1..15");
   end
   if (c_paddle_height > c_game_height) begin : g_bad_paddle
      $error("pong_game_ctrl: paddle taller than the board");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RUNNING   = 2'b01,
      POINT     = 2'b10,
      GAME_OVER = 2'b11
   } state_t;

   state_t             state;
   logic               start_d;
   logic [c_cnt_w-1:0] serve_cnt;
   logic               game_active;
   logic               point_pulse;
   logic [3:0]         p1_score;
   logic [3:0]         p2_score;
   logic [1:0]         winner;

   logic start_edge;
   logic hit1;
   logic hit2;
   logic left_miss;
   logic right_miss;

   // Hit ranges use a 7-bit sum so a paddle near row 63 does not wrap to the top.
   always_comb begin
      start_edge = game.i_start & ~start_d;
      hit1 = ({1'b0, game.i_ball_y} >= {1'b0, game.i_paddle1_y}) &&
             ({1'b0, game.i_ball_y} <= ({1'b0, game.i_paddle1_y} + c_paddle_span));
      hit2 = ({1'b0, game.i_ball_y} >= {1'b0, game.i_paddle2_y}) &&
             ({1'b0, game.i_ball_y} <= ({1'b0, game.i_paddle2_y} + c_paddle_span));
      left_miss  = (game.i_ball_x == 6'd0) && !hit1;
      right_miss = (game.i_ball_x == c_right_col) && !hit2;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         start_d     <= 1'b0;
         serve_cnt   <= '0;
         game_active <= 1'b0;
         point_pulse <= 1'b0;
         p1_score    <= 4'd0;
         p2_score    <= 4'd0;
         winner      <= 2'b00;
      end else begin
         start_d     <= game.i_start;
         point_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state       <= RUNNING;
                  game_active <= 1'b1;
               end
            end
            RUNNING: begin
               if (left_miss) begin
                  if (p2_score != c_limit) p2_score <= p2_score + 4'd1;
                  point_pulse <= 1'b1;
                  game_active <= 1'b0;
                  serve_cnt   <= '0;
                  state       <= POINT;
               end else if (right_miss) begin
                  if (p1_score != c_limit) p1_score <= p1_score + 4'd1;
                  point_pulse <= 1'b1;
                  game_active <= 1'b0;
                  serve_cnt   <= '0;
                  state       <= POINT;
               end
            end
            POINT: begin
               if (serve_cnt == c_cnt_last) begin
                  serve_cnt <= '0;
                  if (p1_score == c_limit || p2_score == c_limit) begin
                     winner <= (p1_score == c_limit) ? 2'b01 : 2'b10;
                     state  <= GAME_OVER;
                  end else begin
                     game_active <= 1'b1;
                     state       <= RUNNING;
                  end
               end else begin
                  serve_cnt <= serve_cnt + c_cnt_w'(1);
               end
            end
            GAME_OVER: begin
               if (start_edge) begin
                  p1_score    <= 4'd0;
                  p2_score    <= 4'd0;
                  winner      <= 2'b00;
                  game_active <= 1'b1;
                  state       <= RUNNING;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign game.o_game_active = game_active;
   assign game.o_p1_score    = p1_score;
   assign game.o_p2_score    = p2_score;
   assign game.o_point_pulse = point_pulse;
   assign game.o_winner      = winner;
   assign game.o_state       = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus random play, all checked
// every cycle against a rule-level model of the match.
module tb_pong_game_ctrl;

   localparam int c_w     = 40;
   localparam int c_h     = 31;
   localparam int c_ph    = 6;
   localparam int c_lim   = 2;
   localparam int c_delay = 16;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   bit   check_en = 1'b0;

   int n_vectors     = 0;
   int n_miscompares = 0;
   int pulse_seen    = 0;

   // Match model: ball in play, serve pause remaining, match over, scores, winner.
   bit m_in_play    = 1'b0;
   bit m_over       = 1'b0;
   bit m_prev_start = 1'b0;
   bit m_pulse      = 1'b0;
   int m_wait       = 0;
   int m_p1         = 0;
   int m_p2         = 0;
   int m_winner     = 0;
   bit m_start_ev;
   bit m_miss_l;
   bit m_miss_r;

   pong_game_ctrl_if game();

   pong_game_ctrl #(
      .c_game_width   (c_w),
      .c_game_height  (c_h),
      .c_paddle_height(c_ph),
      .c_score_limit  (c_lim),
      .c_serve_delay  (c_delay)
   ) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .game   (game.slave)
   );

   always #5 i_clk = ~i_clk;

   function automatic bit onPaddle(input int by, input int py);
      return (by >= py) && (by <= py + c_ph - 1);
   endfunction

   function automatic int expState();
      if (m_in_play) return 1;
      if (m_wait > 0) return 2;
      if (m_over) return 3;
      return 0;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int bx, input int by, input int p1y, input int p2y, input bit st);
      @(negedge i_clk);
      game.i_ball_x    = 6'(bx);
      game.i_ball_y    = 6'(by);
      game.i_paddle1_y = 6'(p1y);
      game.i_paddle2_y = 6'(p2y);
      game.i_start     = st;
   endtask

   // Model advances by the match rules on each clock, clears on reset.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_in_play    = 1'b0;
         m_over       = 1'b0;
         m_prev_start = 1'b0;
         m_pulse      = 1'b0;
         m_wait       = 0;
         m_p1         = 0;
         m_p2         = 0;
         m_winner     = 0;
      end else begin
         m_start_ev   = game.i_start && !m_prev_start;
         m_prev_start = game.i_start;
         m_pulse      = 1'b0;
         m_miss_l     = (game.i_ball_x == 0)       && !onPaddle(int'(game.i_ball_y), int'(game.i_paddle1_y));
         m_miss_r     = (game.i_ball_x == c_w - 1) && !onPaddle(int'(game.i_ball_y), int'(game.i_paddle2_y));
         if (m_in_play) begin
            if (m_miss_l || m_miss_r) begin
               if (m_miss_l) m_p2 = (m_p2 < c_lim) ? m_p2 + 1 : c_lim;
               else          m_p1 = (m_p1 < c_lim) ? m_p1 + 1 : c_lim;
               m_pulse   = 1'b1;
               m_in_play = 1'b0;
               m_wait    = c_delay;
            end
         end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               if (m_p1 == c_lim || m_p2 == c_lim) begin
                  m_over   = 1'b1;
                  m_winner = (m_p1 == c_lim) ? 1 : 2;
               end else begin
                  m_in_play = 1'b1;
               end
            end
         end else if (m_start_ev) begin
            if (m_over) begin
               m_p1     = 0;
               m_p2     = 0;
               m_winner = 0;
               m_over   = 1'b0;
            end
            m_in_play = 1'b1;
         end
      end
   end

   // Every cycle, outputs must match the model.
   always @(negedge i_clk) begin
      if (check_en) begin
         checkOutput("game_active", int'(game.o_game_active), int'(m_in_play));
         checkOutput("p1_score",    int'(game.o_p1_score),    m_p1);
         checkOutput("p2_score",    int'(game.o_p2_score),    m_p2);
         checkOutput("point_pulse", int'(game.o_point_pulse), int'(m_pulse));
         checkOutput("winner",      int'(game.o_winner),      m_winner);
         checkOutput("state",       int'(game.o_state),       expState());
         if (game.o_point_pulse) pulse_seen++;
      end
   end

   initial begin
      int k;
      int pulses0;

      game.i_start     = 1'b0;
      game.i_ball_x    = 6'd20;
      game.i_ball_y    = 6'd15;
      game.i_paddle1_y = 6'd12;
      game.i_paddle2_y = 6'd12;
      repeat (2) @(negedge i_clk);
      check_en = 1'b1;
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Serve from IDLE; a held button gives only one edge.
      applyStimulus(20, 15, 12, 12, 1);
      @(negedge i_clk);
      checkOutput("t1_active_after_edge", int'(game.o_game_active), 1);
      repeat (5) applyStimulus(20, 15, 12, 12, 1);
      applyStimulus(20, 15, 12, 12, 0);
      checkOutput("t1_still_running", int'(game.o_state), 1);

      // Ball on left wall but on paddle 1: nothing happens.
      pulses0 = pulse_seen;
      repeat (100) applyStimulus(0, 10, 8, 12, 0);
      @(negedge i_clk);
      checkOutput("t2_no_pulse", pulse_seen - pulses0, 0);
      checkOutput("t2_state", int'(game.o_state), 1);

      // Left miss with wall dwell: one point, then serve after 16 cycles.
      pulses0 = pulse_seen;
      applyStimulus(0, 20, 8, 12, 0);
      for (k = 1; k <= 40; k++) begin
         @(negedge i_clk);
         if (k == 1) begin
            checkOutput("t3_p2_score", int'(game.o_p2_score), 1);
            checkOutput("t3_active_drop", int'(game.o_game_active), 0);
         end
         if (k == 3) begin
            checkOutput("t3_one_pulse", pulse_seen - pulses0, 1);
            game.i_ball_x = 6'd20;
         end
         if (game.o_state == 2'b01) break;
      end
      checkOutput("t3_serve_len", k, c_delay + 1);

      // Right wall: bottom paddle row is a hit, one row below is a miss.
      repeat (5) applyStimulus(39, 29, 8, 24, 0);
      @(negedge i_clk);
      checkOutput("t4_hit_p1", int'(game.o_p1_score), 0);
      applyStimulus(39, 30, 8, 24, 0);
      @(negedge i_clk);
      checkOutput("t4_miss_p1", int'(game.o_p1_score), 1);
      checkOutput("t4_state_point", int'(game.o_state), 2);
      applyStimulus(20, 15, 8, 24, 0);

      // Async reset in POINT clears outputs before the next clock edge.
      repeat (2) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("t6_active", int'(game.o_game_active), 0);
      checkOutput("t6_p1", int'(game.o_p1_score), 0);
      checkOutput("t6_state", int'(game.o_state), 0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // Two right misses reach the limit of 2; restart via start edge.
      applyStimulus(20, 15, 12, 12, 1);
      applyStimulus(20, 15, 12, 12, 0);
      for (int m = 0; m < 2; m++) begin
         applyStimulus(39, 0, 8, 24, 0);
         applyStimulus(20, 15, 8, 24, 0);
         for (int w = 0; w < 40; w++) begin
            @(negedge i_clk);
            if (game.o_state != 2'b10) break;
         end
      end
      checkOutput("t5_state_over", int'(game.o_state), 3);
      checkOutput("t5_winner", int'(game.o_winner), 1);
      checkOutput("t5_p1", int'(game.o_p1_score), 2);
      checkOutput("t5_p2", int'(game.o_p2_score), 0);
      repeat (10) applyStimulus(39, 0, 8, 24, 0);
      checkOutput("t5_held_p1", int'(game.o_p1_score), 2);
      applyStimulus(20, 15, 8, 24, 1);
      @(negedge i_clk);
      checkOutput("t5_restart_p1", int'(game.o_p1_score), 0);
      checkOutput("t5_restart_state", int'(game.o_state), 1);

      // Random play against the model.
      for (int c = 0; c < 3000; c++) begin
         int bx;
         int by;
         int p1y;
         int p2y;
         int sel;
         bit st;
         p1y = $urandom_range(0, 63);
         p2y = $urandom_range(0, 63);
         sel = $urandom_range(0, 7);
         bx  = (sel == 0) ? 0 : (sel == 1) ? c_w - 1 : $urandom_range(1, c_w - 2);
         if ($urandom_range(0, 3) == 0) by = $urandom_range(0, 63);
         else by = ((sel == 0) ? p1y : p2y) + $urandom_range(0, 7);
         if (by > 63) by = 63;
         st = ($urandom_range(0, 9) == 0) ? !game.i_start : game.i_start;
         applyStimulus(bx, by, p1y, p2y, st);
      end
      @(negedge i_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
